smp_pipe: RTL

Multi-channel, pipelined, flow-controlled successor of the sample logic cell. Each of G_CH channels takes a 4-bit vector D and produces QX = (D[0] & D[1]) | D[2] and QY = ~(QX | D[3]). Results are registered behind a valid/ready handshake, with selectable latency. A saturating counter tracks output beats that carry any asserted QY. The block sits between a streaming source and a consumer that may stall.

---
 rtl/smp_pkg.sv | 27 ++
 rtl/smp_stage.sv | 49 ++++
 rtl/smp_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/smp_pkg.sv
// Shared types and per-channel logic functions for the smp_pipe slice.
// Ports: none (package). Exports C_D_W, smp_in_t, smp_out_t, f_n1, f_qx, f_qy.
// The functions are the single definition of the channel logic; both latency modes use them.
package smp_pkg;

    localparam int C_D_W = 4;

    typedef logic [C_D_W-1:0] smp_in_t;

    typedef struct packed {
        logic qx;
        logic qy;
    } smp_out_t;

    function automatic logic f_n1(input smp_in_t d);
        return d[0] & d[1];
    endfunction

    function automatic logic f_qx(input smp_in_t d);
        return f_n1(d) | d[2];
    endfunction

    function automatic logic f_qy(input smp_in_t d);
        return ~(f_qx(d) | d[3]);
    endfunction

endpackage

// File: rtl/smp_stage.sv
// One valid/ready register slice: loads upstream data when enabled and upstream is valid.
// Ports: CLK/RST, up_vld_i/up_dat_i from upstream, en_nxt_i from downstream,
//        en_o (this slice can take a beat), v_o/dat_o (held beat).
module smp_stage
    import smp_pkg::*;
#(
    parameter int P_W = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           up_vld_i,
    input  logic [P_W-1:0] up_dat_i,
    input  logic           en_nxt_i,
    output logic           en_o,
    output logic           v_o,
    output logic [P_W-1:0] dat_o
);

    logic           v_q,   v_d;
    logic [P_W-1:0] dat_q, dat_d;

    // An empty slice always has room; a full one only when its beat moves on.
    assign en_o = ~v_q | en_nxt_i;

    always_comb begin
        v_d   = v_q;
        dat_d = dat_q;
        if (en_o) begin
            v_d = up_vld_i;
            if (up_vld_i) begin
                dat_d = up_dat_i;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q   <= 1'b0;
            dat_q <= '0;
        end else begin
            v_q   <= v_d;
            dat_q <= dat_d;
        end
    end

    assign v_o   = v_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/smp_pipe.sv
// Multi-channel pipelined logic cell: QX=(D0&D1)|D2, QY=~(QX|D3) per channel, valid/ready flow.
// Ports: CLK/RST/CLR, I_VLD/I_RDY/D input stream, O_VLD/O_RDY/QX/QY output stream,
//        CNT saturating count of output transfers carrying any QY bit.
module smp_pipe
    import smp_pkg::*;
#(
    parameter logic G_MODE  = 1'b0,
    parameter int   G_CH    = 4,
    parameter int   G_CNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic                  I_VLD,
    output logic                  I_RDY,
    input  logic [C_D_W*G_CH-1:0] D,
    output logic                  O_VLD,
    input  logic                  O_RDY,
    output logic [G_CH-1:0]       QX,
    output logic [G_CH-1:0]       QY,
    output logic [G_CNT_W-1:0]    CNT
);

    // Final stage word: QX in the low G_CH bits, QY in the high G_CH bits.
    logic [2*G_CH-1:0] out_dat;

    if (G_MODE == 1'b0) begin : g_one
        logic [2*G_CH-1:0] res;

        for (genvar c = 0; c < G_CH; c++) begin : g_ch
            assign res[c]        = f_qx(D[C_D_W*c +: C_D_W]);
            assign res[G_CH + c] = f_qy(D[C_D_W*c +: C_D_W]);
        end

        smp_stage #(.P_W(2*G_CH)) u_st (
            .CLK      (CLK),
            .RST      (RST),
            .up_vld_i (I_VLD),
            .up_dat_i (res),
            .en_nxt_i (O_RDY),
            .en_o     (I_RDY),
            .v_o      (O_VLD),
            .dat_o    (out_dat)
        );
    end else begin : g_two
        // Stage-1 word: n1 in [G_CH-1:0], D2 in [2G_CH-1:G_CH], D3 in [3G_CH-1:2G_CH].
        logic [3*G_CH-1:0] s1_in, s1_dat;
        logic [2*G_CH-1:0] s2_in;
        logic              s1_v, s2_en;

        for (genvar c = 0; c < G_CH; c++) begin : g_ch
            smp_in_t rebuilt;
            assign s1_in[c]          = f_n1(D[C_D_W*c +: C_D_W]);
            assign s1_in[G_CH + c]   = D[C_D_W*c + 2];
            assign s1_in[2*G_CH + c] = D[C_D_W*c + 3];
            // n1 placed on both low bits so f_n1 returns it unchanged and the
            // same f_qx/f_qy apply in stage 2.
            assign rebuilt = {s1_dat[2*G_CH + c], s1_dat[G_CH + c], s1_dat[c], s1_dat[c]};
            assign s2_in[c]        = f_qx(rebuilt);
            assign s2_in[G_CH + c] = f_qy(rebuilt);
        end

        smp_stage #(.P_W(3*G_CH)) u_st1 (
            .CLK      (CLK),
            .RST      (RST),
            .up_vld_i (I_VLD),
            .up_dat_i (s1_in),
            .en_nxt_i (s2_en),
            .en_o     (I_RDY),
            .v_o      (s1_v),
            .dat_o    (s1_dat)
        );

        smp_stage #(.P_W(2*G_CH)) u_st2 (
            .CLK      (CLK),
            .RST      (RST),
            .up_vld_i (s1_v),
            .up_dat_i (s2_in),
            .en_nxt_i (O_RDY),
            .en_o     (s2_en),
            .v_o      (O_VLD),
            .dat_o    (out_dat)
        );
    end

    assign QX = out_dat[G_CH-1:0];
    assign QY = out_dat[2*G_CH-1:G_CH];

    localparam logic [G_CNT_W-1:0] C_CNT_MAX = '1;

    logic [G_CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority over a same-cycle counted transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (O_VLD && O_RDY && (|QY) && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + G_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule
